// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: format codes, opcodes, field widths.
package instruction_encoder_pkg;

  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int ADDR_W   = 26;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_RSV = 2'b11
  } fmt_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;

  function automatic logic is_branch(input logic [OPCODE_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/instruction_encoder_pack.sv
// Combinational packer: fields + current pointer -> 32-bit instruction word and error bit.
// ENC_BRANCH_REL_EN turns beq/bne and J targets into relative/region-encoded fields.
module instr_pack
  import instruction_encoder_pkg::*;
(
  input  logic [1:0]          fmt,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [IMM_W-1:0]    imm,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         target,
  input  logic [31:0]         pointer,
  output logic [WORD_W-1:0]   word,
  output logic                err
);

  logic [IMM_W-1:0]  imm_f;
  logic [ADDR_W-1:0] addr_f;

`ifdef ENC_BRANCH_REL_EN
  logic [31:0] next_pc;
  logic [29:0] word_off;

  assign next_pc  = pointer + 32'd4;
  // Word offset as a signed 30-bit quantity; it fits 16 bits when bits [29:15] agree.
  assign word_off = 30'((target - next_pc) >> 2);
`else
  logic unused_rel;
  assign unused_rel = ^{target, pointer};
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    word   = '0;
    err    = 1'b0;
    imm_f  = imm;
    addr_f = addr;
`ifdef ENC_BRANCH_REL_EN
    if (fmt == FMT_I && is_branch(opcode)) begin
      imm_f = word_off[IMM_W-1:0];
      err   = (target[1:0] != 2'b00) ||
              !((&word_off[29:15]) || !(|word_off[29:15]));
    end else if (fmt == FMT_J) begin
      addr_f = target[27:2];
      err    = (target[1:0] != 2'b00) || (target[31:28] != next_pc[31:28]);
    end
`endif
    case (fmt)
      FMT_R:   word = {opcode, rs, rt, rd, shamt, funct};
      FMT_I:   word = {opcode, rs, rt, imm_f};
      FMT_J:   word = {opcode, addr_f};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming MIPS instruction encoder: valid/ready field bundles in, packed words with PCs out.
// Optional relative branch/jump target encoding is enabled with ENC_BRANCH_REL_EN.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    fmt,
  input  logic [5:0]                    opcode,
  input  logic [4:0]                    rs,
  input  logic [4:0]                    rt,
  input  logic [4:0]                    rd,
  input  logic [4:0]                    shamt,
  input  logic [5:0]                    funct,
  input  logic [15:0]                   imm,
  input  logic [25:0]                   addr,
  input  logic [31:0]                   target,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [31:0]                   out_pc,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0] pointer;
  logic [31:0] packed_word;
  logic        pack_err;
  logic        accept;
  logic        legal;
  logic        out_hs;

  instr_pack u_pack (
    .fmt     (fmt),
    .opcode  (opcode),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .shamt   (shamt),
    .funct   (funct),
    .imm     (imm),
    .addr    (addr),
    .target  (target),
    .pointer (pointer),
    .word    (packed_word),
    .err     (pack_err)
  );

  assign full     = (count == CNT_W'(DEPTH));
  // NOTE: reset_n is folded in so the producer never sees ready while the block is held in reset.
  assign in_ready = reset_n && !full && (!out_valid || out_ready) && !clear;
  assign accept   = in_valid && in_ready;
  assign legal    = (fmt != FMT_RSV);
  assign out_hs   = out_valid && out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pointer   <= BASE_ADDR;
      count     <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= BASE_ADDR;
      err       <= 1'b0;
    end else if (clear) begin
      pointer   <= BASE_ADDR;
      count     <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= BASE_ADDR;
      err       <= 1'b0;
    end else if (accept && legal) begin
      out_valid <= 1'b1;
      out_instr <= packed_word;
      out_pc    <= pointer;
      pointer   <= pointer + 32'd4;
      count     <= count + 1'b1;
      if (pack_err) err <= 1'b1;
    end else begin
      // Reserved format completes the handshake but only flags the error.
      if (accept) err <= 1'b1;
      if (out_hs) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: spec vectors, corner sequences, random vs model.
module tb_instruction_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n, clear, in_valid, out_ready;
  logic        in_ready, out_valid, full, err;
  logic [1:0]  fmt;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] addr;
  logic [31:0] target, out_instr, out_pc;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_ptr, m_instr, m_pc;
  int          m_count;
  logic        m_ov, m_err;

  always #5 clk = ~clk;

  instruction_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .addr(addr), .target(target), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count), .full(full), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Word built from the field layout with plain arithmetic (no bit concatenation).
  function automatic void ref_pack(input logic [1:0] f, input logic [5:0] op,
      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ad,
      input logic [31:0] tg, input logic [31:0] ptr, output logic [31:0] w, output logic e);
    longint v;
    int     off;
    e = 1'b0;
`ifdef ENC_BRANCH_REL_EN
    if (f == 2'd1 && (op == 6'd4 || op == 6'd5)) begin
      off = int'(tg - (ptr + 32'd4)) >>> 2;
      if (off < -32768 || off > 32767 || (tg % 4) != 0) e = 1'b1;
      im = 16'(off);
    end else if (f == 2'd2) begin
      ad = 26'((tg / 4) % 67108864);
      if ((tg / 268435456) != ((ptr + 32'd4) / 268435456) || (tg % 4) != 0) e = 1'b1;
    end
`endif
    case (f)
      2'd0: v = longint'(op) * 67108864 + longint'(s) * 2097152 + longint'(t) * 65536 +
                longint'(d) * 2048 + longint'(sh) * 64 + longint'(fn);
      2'd1: v = longint'(op) * 67108864 + longint'(s) * 2097152 + longint'(t) * 65536 +
                longint'(im);
      default: v = longint'(op) * 67108864 + longint'(ad);
    endcase
    w = v[31:0];
  endfunction

  task automatic model_reset();
    m_ptr = BASE; m_count = 0; m_ov = 1'b0; m_instr = '0; m_pc = BASE; m_err = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic        exp_rdy, acc, e;
    logic [31:0] w;
    @(negedge clk);
    exp_rdy = (m_count != DEPTH) && (!m_ov || out_ready) && !clear;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check("count", {29'd0, count}, 32'(m_count));
    check("full", {31'd0, full}, {31'd0, m_count == DEPTH});
    check("err", {31'd0, err}, {31'd0, m_err});
    if (m_ov) begin
      check("out_instr", out_instr, m_instr);
      check("out_pc", out_pc, m_pc);
    end
    @(posedge clk);
    acc = in_valid && exp_rdy;
    if (clear) begin
      model_reset();
    end else if (acc && fmt != 2'd3) begin
      ref_pack(fmt, opcode, rs, rt, rd, shamt, funct, imm, addr, target, m_ptr, w, e);
      m_ov = 1'b1; m_instr = w; m_pc = m_ptr; m_ptr = m_ptr + 32'd4; m_count++;
      if (e) m_err = 1'b1;
    end else begin
      if (acc) m_err = 1'b1;
      if (m_ov && out_ready) m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic set_fields(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] im, input logic [25:0] ad, input logic [31:0] tg);
    fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
    imm = im; addr = ad; target = tg;
  endtask

  task automatic do_clear();
    clear = 1'b1; in_valid = 1'b0; cycle(); clear = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  f;
    logic [5:0]  op;
    logic [4:0]  s, t, d, sh;
    logic [5:0]  fn;
    logic [15:0] im;
    logic [25:0] ad;
    logic [31:0] tg;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] held;

  initial begin
    vecs[0] = '{2'd0, 6'h00, 5'd21, 5'd7, 5'd29, 5'd0, 6'h20, 16'h0, 26'h0, 32'h0, 32'h02A7E820};
    vecs[1] = '{2'd1, 6'h08, 5'd21, 5'd7, 5'd0, 5'd0, 6'h0, 16'hEB23, 26'h0, 32'h0, 32'h22A7EB23};
    vecs[2] = '{2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h2A7EB23, 32'h0A9FAC8C,
                32'h0AA7EB23};
    vecs[3] = '{2'd0, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0, 26'h0, 32'h0, 32'hFFFFFFFF};
    vecs[4] = '{2'd1, 6'h23, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 32'h0, 32'h8C000000};

    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_instr", out_instr, 32'd0);
    check("rst out_pc", out_pc, BASE);
    check("rst count", {29'd0, count}, 32'd0);
    check("rst full_err", {30'd0, full, err}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    model_reset();

    // Spec vectors, each packed from a freshly cleared pointer
    for (int i = 0; i < 5; i++) begin
      do_clear();
      set_fields(vecs[i].f, vecs[i].op, vecs[i].s, vecs[i].t, vecs[i].d, vecs[i].sh,
                 vecs[i].fn, vecs[i].im, vecs[i].ad, vecs[i].tg);
      in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      check($sformatf("vec%0d instr", i), out_instr, vecs[i].exp);
      check($sformatf("vec%0d pc", i), out_pc, 32'h0);
      check($sformatf("vec%0d valid", i), {31'd0, out_valid}, 32'd1);
      cycle();
    end

    // I then J back-to-back
    do_clear();
    out_ready = 1'b1; in_valid = 1'b1;
    set_fields(2'd1, 6'h08, 5'd21, 5'd7, 5'd0, 5'd0, 6'h0, 16'hEB23, 26'h0, 32'h0);
    cycle();
    check("b2b I instr", out_instr, 32'h22A7EB23);
    check("b2b I pc", out_pc, 32'h0);
    set_fields(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h2A7EB23, 32'h0A9FAC8C);
    cycle();
    check("b2b J instr", out_instr, 32'h0AA7EB23);
    check("b2b J pc", out_pc, 32'h4);
    check("b2b J valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    cycle();

    // Backpressure: output held, inputs blocked, exactly one more accept after release
    do_clear();
    out_ready = 1'b0; in_valid = 1'b1;
    set_fields(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd4, 6'h25, 16'h0, 26'h0, 32'h0);
    cycle();
    held = 32'h00221925;
    set_fields(2'd1, 6'h08, 5'd9, 5'd9, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
      check("bp held", out_instr, held);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("bp second word", out_instr, 32'h21291234);
    check("bp count", {29'd0, count}, 32'd2);
    cycle();

    // Fill to DEPTH, clear, then a reserved format
    do_clear();
    out_ready = 1'b1; in_valid = 1'b1;
    set_fields(2'd0, 6'h00, 5'd3, 5'd3, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0, 32'h0);
    repeat (DEPTH) cycle();
    check("full flag", {31'd0, full}, 32'd1);
    check("full count", {29'd0, count}, 32'(DEPTH));
    check("full in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) cycle();
    do_clear();
    in_valid = 1'b1;
    cycle();
    check("clear count", {29'd0, count}, 32'd1);
    check("clear pc", out_pc, 32'h0);
    fmt = 2'd3;
    cycle();
    in_valid = 1'b0;
    check("rsv err", {31'd0, err}, 32'd1);
    check("rsv count", {29'd0, count}, 32'd1);
    cycle();

`ifdef ENC_BRANCH_REL_EN
    // beq three words in (pointer 0xC) to target 0x0 -> offset -4
    do_clear();
    in_valid = 1'b1; out_ready = 1'b1;
    set_fields(2'd0, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h20, 16'h0, 26'h0, 32'h0);
    repeat (3) cycle();
    set_fields(2'd1, 6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 32'h0);
    cycle();
    check("beq imm", {16'd0, out_instr[15:0]}, 32'h0000FFFC);
    check("beq err", {31'd0, err}, 32'd0);
    do_clear();
    in_valid = 1'b1;
    set_fields(2'd1, 6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 32'h6);
    cycle();
    in_valid = 1'b0;
    check("beq misaligned err", {31'd0, err}, 32'd1);
    cycle();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      clear     = ($urandom_range(0, 11) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_fields(($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                 ($urandom_range(0, 3) == 0) ? 6'h04 : 6'($urandom),
                 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                 16'($urandom), 26'($urandom),
                 ($urandom_range(0, 5) == 0) ? $urandom
                   : m_ptr + 32'd4 + 32'(($urandom_range(0, 64) - 32) * 4));
      cycle();
    end
    clear = 1'b0;

    // Asynchronous reset while a word is pending
    in_valid = 1'b1; out_ready = 1'b0; fmt = 2'd0;
    cycle();
    #2 reset_n = 1'b0;
    #1;
    check("async out_valid", {31'd0, out_valid}, 32'd0);
    check("async out_instr", out_instr, 32'd0);
    check("async out_pc", out_pc, BASE);
    check("async count", {29'd0, count}, 32'd0);
    check("async full_err", {30'd0, full, err}, 32'd0);
    check("async in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Streaming MIPS instruction encoder: accepts decoded field bundles (R, I or J format) over a valid/ready handshake, packs them into 32-bit instruction words, and emits each word with its assigned program address. It is the inverse of the instruction decoder and sits between the test/program generator and instruction-memory load logic. It keeps a write pointer, a word count and a full flag, so a program can be streamed in one word per cycle.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address assigned to the first word after reset/clear
- DEPTH, 1024, maximum words accepted before `full`
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous restart: pointer, count, output and err cleared
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- fmt  in  2  00 R, 01 I, 10 J, 11 reserved
- opcode  in  6;  rs, rt, rd, shamt  in  5 each;  funct  in  6;  imm  in  16;  addr  in  26  instruction fields
- target  in  32  absolute byte target (used only with ENC_BRANCH_REL_EN)
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_pc  out  32  byte address of out_instr
- count  out  $clog2(DEPTH+1)  words accepted since reset/clear
- full  out  1  count == DEPTH
- err  out  1  sticky error flag

## Operation
- Packing: R = {opcode,rs,rt,rd,shamt,funct}; I = {opcode,rs,rt,imm}; J = {opcode,addr}. R opcode is taken as given, not forced to 0.
- Accept when in_valid && in_ready. in_ready = !full && (!out_valid || out_ready) && !clear. It is 0 while reset_n is low.
- On accept with legal fmt:
  - Output register loads the word; out_pc = pointer.
  - Pointer += 4 (32-bit wrap); count += 1.
- fmt 11 on accept: the handshake completes, nothing is emitted, pointer and count are unchanged, and err is set.
- Output register holds its contents while out_valid && !out_ready. Inputs are not sampled in that state.
- out_valid clears on an output handshake with no simultaneous accept. Accept and output handshake in the same cycle give back-to-back words.
- clear has priority over all handshakes:
  - pointer returns to BASE_ADDR; count, out_valid and err return to 0.
  - A pending output word is discarded.
- full blocks input. The output register still drains.
- Reset values: out_valid 0, out_instr 0, out_pc BASE_ADDR, count 0, full 0, err 0; internal pointer BASE_ADDR.

## Timing
- Latency: 1 cycle from accept edge to out_valid/out_instr/out_pc.
- Throughput: 1 word/cycle with out_ready held high.
- in_ready is combinational from out_valid, out_ready, full and clear. There is no combinational path from in_valid to out_*.
- Reset asserted mid-transfer drops the word immediately (asynchronous).
- count/full update on the accept edge. The DEPTH-th accept raises full on that edge.

## Configuration
- ENC_BRANCH_REL_EN defined:
  - I format with opcode 000100/000101 (beq/bne): imm field = (target − (pointer+4)) >> 2, truncated to 16 bits.
  - err is set if the offset does not fit signed 16 bits or target[1:0] != 0.
  - J format: addr field = target[27:2]. err is set if target[31:28] != (pointer+4)[31:28] or target[1:0] != 0.
  - An error still emits the truncated word.
- ENC_BRANCH_REL_EN undefined: imm/addr are passed through raw; target is ignored; err comes only from fmt 11.

## Structure
- Shared package holds:
  - format codes FMT_R/FMT_I/FMT_J/FMT_RSV
  - opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_ADDI
  - field width constants
- One combinational sub-module `instr_pack` computes the 32-bit word and error bit from the fields and pointer.
- The top level holds the handshake, pointer, count and output register.

## Test plan
- R accept: fmt 00, rs 21, rt 7, rd 29, shamt 0, funct 0x20 -> out_instr 0x02A7E820, out_pc 0x00000000 one cycle later.
- I then J back-to-back, out_ready high:
  - I: opcode 0x08, rs 21, rt 7, imm 0xEB23 -> 0x22A7EB23 at pc 0x0.
  - J: opcode 0x02, addr 0x2A7EB23 -> 0x0AA7EB23 at pc 0x4.
  - No bubble between the two words.
- Backpressure: out_ready low for 3 cycles with in_valid high -> in_ready 0, out_instr held stable; a single accept occurs after release.
- Full/clear with DEPTH=4:
  - After 4 accepts: full=1, in_ready=0.
  - clear -> count 0, out_pc of the next word 0x0.
  - fmt 11 -> err=1, count unchanged.
- ENC_BRANCH_REL_EN:
  - beq at pointer 0x10 with target 0x4 -> imm 0xFFFC.
  - target 0x6 -> err=1.
  - Reset asserted mid-stream -> all outputs return to their reset values immediately.
